// File: rtl/srambank_param_init.sv
// Parametrised single-port SRAM bank with lane write mask, 1- or 2-cycle read latency,
// a post-reset clear sweep (busy) and a registered error pulse for collisions / out-of-range.
module srambank_param_init #(
    parameter int              WORDS    = 1024,
    parameter int              ADDR_W   = 10,
    parameter int              WIDTH    = 16,
    parameter int              LANES    = 4,
    parameter int              RD_LAT   = 1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [WIDTH-1:0]  wd,
    input  logic [LANES-1:0]  wmask,
    input  logic              banksel,
    input  logic              read,
    input  logic              write,
    output logic [WIDTH-1:0]  dataout,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);
    localparam int LW = WIDTH / LANES;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_W:0] WORDS_L = (ADDR_W + 1)'(WORDS);
    localparam logic [IW-1:0]   LAST    = IW'(WORDS - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IW-1:0]    ptr;
    logic             clr_we;

    logic             ready;
    logic             oor;
    logic             acc;
    logic             wr_en;
    logic             rd_en;
    logic             err_nxt;
    logic [IW-1:0]    aidx;

    logic [WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (clr_we)
                ptr <= ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && ptr == LAST)
            state_nxt = READY;
    end

    always_comb begin
        busy   = (state == CLEAR);
        clr_we = (state == CLEAR) && !reset;
    end

    // Request decode: only READY accepts; out-of-range or read+write collisions flag err
    assign ready   = (state == READY) && !reset;
    assign oor     = {1'b0, ADDRESS} >= WORDS_L;
    assign acc     = ready && banksel && (read || write);
    assign wr_en   = acc && write && !oor;
    assign rd_en   = acc && read && !write && !oor;
    assign err_nxt = acc && (oor || (read && write));
    assign aidx    = ADDRESS[IW-1:0];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[ptr] <= INIT_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++)
                if (wmask[i])
                    mem[aidx][i*LW +: LW] <= wd[i*LW +: LW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            err <= 1'b0;
        else
            err <= err_nxt;
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            // p0: array read lands directly on the output register
            always_ff @(posedge clk) begin
                if (reset) begin
                    dataout <= '0;
                    rvalid  <= 1'b0;
                end else begin
                    rvalid <= rd_en;
                    if (rd_en)
                        dataout <= mem[aidx];
                end
            end
        end else if (RD_LAT == 2) begin : g_lat2
            logic [WIDTH-1:0] rdata_p0;
            logic             vld_p0;

            // p0: array read
            always_ff @(posedge clk) begin
                if (reset)
                    vld_p0 <= 1'b0;
                else
                    vld_p0 <= rd_en;
                if (rd_en)
                    rdata_p0 <= mem[aidx];
            end

            // p1: output register
            always_ff @(posedge clk) begin
                if (reset) begin
                    dataout <= '0;
                    rvalid  <= 1'b0;
                end else begin
                    rvalid <= vld_p0;
                    if (vld_p0)
                        dataout <= rdata_p0;
                end
            end
        end else begin : g_bad_lat
            $error("srambank_param_init: RD_LAT must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_srambank_param_init.sv
// Bench for srambank_param_init: two instances (1024 words / latency 1, 1000 words / latency 2)
// share one randomized stimulus stream and are compared each cycle against a word-array model.
module tb_srambank_param_init;
    localparam int AW = 10;
    localparam int WD = 16;
    localparam int LN = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [WD-1:0] wd;
    logic [LN-1:0] wmask;
    logic          banksel;
    logic          rd;
    logic          wr;
    logic [WD-1:0] dout_a, dout_b;
    logic          rvalid_a, rvalid_b, busy_a, busy_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    srambank_param_init #(.WORDS(1024), .ADDR_W(AW), .WIDTH(WD), .LANES(LN),
                          .RD_LAT(1), .INIT_VAL(16'h0000)) dut_a (
        .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd), .wmask(wmask),
        .banksel(banksel), .read(rd), .write(wr),
        .dataout(dout_a), .rvalid(rvalid_a), .busy(busy_a), .err(err_a));

    srambank_param_init #(.WORDS(1000), .ADDR_W(AW), .WIDTH(WD), .LANES(LN),
                          .RD_LAT(2), .INIT_VAL(16'h5A5A)) dut_b (
        .clk(clk), .reset(reset), .ADDRESS(addr), .wd(wd), .wmask(wmask),
        .banksel(banksel), .read(rd), .write(wr),
        .dataout(dout_b), .rvalid(rvalid_b), .busy(busy_b), .err(err_b));

    // Reference model: word arrays, a sweep countdown and a schedule of read results by cycle
    logic [WD-1:0] mm      [2][1024];
    int            busy_left [2];
    logic          sched_v [2][4];
    logic [WD-1:0] sched_d [2][4];
    logic [WD-1:0] e_dout  [2];
    logic          e_rv    [2];
    logic          e_err   [2];
    int            cyc = 0;

    function automatic int words_of(input int k);
        return (k == 0) ? 1024 : 1000;
    endfunction

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic logic [WD-1:0] init_of(input int k);
        return (k == 0) ? 16'h0000 : 16'h5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_edge(input int k);
        int w;
        int a;
        int slot;
        w = words_of(k);
        a = int'(addr);
        if (reset) begin
            busy_left[k] = w;
            for (int i = 0; i < w; i++) mm[k][i] = init_of(k);
            for (int i = 0; i < 4; i++) sched_v[k][i] = 1'b0;
            e_dout[k] = '0;
            e_rv[k]   = 1'b0;
            e_err[k]  = 1'b0;
            return;
        end
        e_err[k] = 1'b0;
        if (busy_left[k] > 0) begin
            busy_left[k]--;
        end else if (banksel && (rd || wr)) begin
            if (a >= w) begin
                e_err[k] = 1'b1;
            end else if (wr) begin
                for (int l = 0; l < LN; l++)
                    if (wmask[l]) mm[k][a][l*4 +: 4] = wd[l*4 +: 4];
                if (rd) e_err[k] = 1'b1;
            end else begin
                slot = (cyc + lat_of(k) - 1) % 4;
                sched_v[k][slot] = 1'b1;
                sched_d[k][slot] = mm[k][a];
            end
        end
        slot = cyc % 4;
        e_rv[k] = sched_v[k][slot];
        if (sched_v[k][slot]) begin
            e_dout[k] = sched_d[k][slot];
            sched_v[k][slot] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        cyc++;
        @(negedge clk);
        chk("busy_a",   32'(busy_a),   32'(busy_left[0] > 0));
        chk("rvalid_a", 32'(rvalid_a), 32'(e_rv[0]));
        chk("err_a",    32'(err_a),    32'(e_err[0]));
        chk("dout_a",   32'(dout_a),   32'(e_dout[0]));
        chk("busy_b",   32'(busy_b),   32'(busy_left[1] > 0));
        chk("rvalid_b", 32'(rvalid_b), 32'(e_rv[1]));
        chk("err_b",    32'(err_b),    32'(e_err[1]));
        chk("dout_b",   32'(dout_b),   32'(e_dout[1]));
    endtask

    task automatic drive(input logic bs, input logic r, input logic w, input int a,
                         input logic [WD-1:0] d, input logic [LN-1:0] m);
        banksel = bs;
        rd      = r;
        wr      = w;
        addr    = AW'(a);
        wd      = d;
        wmask   = m;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 16'h0, 4'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
    endtask

    task automatic count_busy(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 1100; i++) begin
            if (busy_a) na++;
            if (busy_b) nb++;
            idle(1);
        end
    endtask

    task automatic rand_run(input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = int'($urandom_range(990, 1023));
            else
                a = int'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) == 0), a, 16'($urandom), 4'($urandom));
        end
    endtask

    initial begin
        int na, nb;
        for (int k = 0; k < 2; k++) begin
            busy_left[k] = 0;
            e_dout[k] = '0;
            e_rv[k] = 1'b0;
            e_err[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                sched_v[k][i] = 1'b0;
                sched_d[k][i] = '0;
            end
        end
        reset = 1'b1;
        banksel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wd = '0; wmask = '0;
        idle(1);

        // T1: sweep length and cleared contents
        do_reset();
        chk("t1_reset_dout_a", 32'(dout_a), 32'h0);
        chk("t1_reset_dout_b", 32'(dout_b), 32'h0);
        count_busy(na, nb);
        chk("t1_busy_cycles_a", 32'(na), 32'd1024);
        chk("t1_busy_cycles_b", 32'(nb), 32'd1000);
        drive(1, 1, 0, 0,    16'h0, 4'h0);
        drive(1, 1, 0, 511,  16'h0, 4'h0);
        drive(1, 1, 0, 1023, 16'h0, 4'h0);
        chk("t1_rd1023_a", 32'(dout_a), 32'h0);
        chk("t1_rd1023_rv_a", 32'(rvalid_a), 32'h1);
        chk("t1_rd1023_err_b", 32'(err_b), 32'h1);
        idle(1);
        chk("t1_rd511_b", 32'(dout_b), 32'h5A5A);

        // T2: masked writes then immediate read-back
        drive(1, 0, 1, 5, 16'hABCD, 4'b1111);
        drive(1, 0, 1, 5, 16'h1234, 4'b0101);
        drive(1, 1, 0, 5, 16'h0, 4'h0);
        chk("t2_dout_a", 32'(dout_a), 32'hA2C4);
        idle(1);
        chk("t2_dout_b", 32'(dout_b), 32'hA2C4);
        chk("t2_rv_b", 32'(rvalid_b), 32'h1);

        // T3: back-to-back reads on the latency-2 instance
        drive(1, 0, 1, 1, 16'h1111, 4'hF);
        drive(1, 0, 1, 2, 16'h2222, 4'hF);
        drive(1, 0, 1, 3, 16'h3333, 4'hF);
        drive(1, 1, 0, 1, 16'h0, 4'h0);
        chk("t3_rv0_b", 32'(rvalid_b), 32'h0);
        drive(1, 1, 0, 2, 16'h0, 4'h0);
        chk("t3_d1_b", 32'(dout_b), 32'h1111);
        drive(1, 1, 0, 3, 16'h0, 4'h0);
        chk("t3_d2_b", 32'(dout_b), 32'h2222);
        idle(1);
        chk("t3_d3_b", 32'(dout_b), 32'h3333);
        chk("t3_rv3_b", 32'(rvalid_b), 32'h1);
        idle(1);
        chk("t3_rv_end_b", 32'(rvalid_b), 32'h0);

        // T4: collision writes, drops the read, flags err; zero-mask write is a no-op
        drive(1, 1, 1, 7, 16'h00FF, 4'hF);
        chk("t4_err_a", 32'(err_a), 32'h1);
        chk("t4_rv_a", 32'(rvalid_a), 32'h0);
        drive(1, 0, 1, 7, 16'hFFFF, 4'h0);
        chk("t4_err_clear_a", 32'(err_a), 32'h0);
        drive(1, 1, 0, 7, 16'h0, 4'h0);
        chk("t4_dout_a", 32'(dout_a), 32'h00FF);
        idle(1);
        chk("t4_dout_b", 32'(dout_b), 32'h00FF);

        // T5: address 1000 is valid for a, out of range for b
        drive(1, 0, 1, 1000, 16'hBEEF, 4'hF);
        chk("t5_wr_err_b", 32'(err_b), 32'h1);
        drive(1, 1, 0, 1000, 16'h0, 4'h0);
        chk("t5_rd_err_b", 32'(err_b), 32'h1);
        chk("t5_dout_a", 32'(dout_a), 32'hBEEF);
        idle(1);
        chk("t5_rv_b", 32'(rvalid_b), 32'h0);
        chk("t5_hold_b", 32'(dout_b), 32'h00FF);

        rand_run(1500);

        // Read in flight at reset must not surface
        drive(1, 1, 0, 2, 16'h0, 4'h0);
        do_reset();
        idle(1);
        chk("flush_rv_b", 32'(rvalid_b), 32'h0);

        // T6: reset mid-sweep restarts it
        do_reset();
        rand_run(300);
        do_reset();
        count_busy(na, nb);
        chk("t6_busy_cycles_a", 32'(na), 32'd1024);
        chk("t6_busy_cycles_b", 32'(nb), 32'd1000);

        rand_run(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
